// File: rtl/cpu_intgen_pkg.sv
// Shared constants for the CPU interrupt blocks: default NMI acknowledge
// address, default prescale, synchroniser depth and the IRQ vector.
package cpu_intgen_pkg;

  localparam int unsigned PRESCALE_DEFAULT     = 512;
  localparam int unsigned SYNC_STAGES_DEFAULT  = 2;
  localparam logic [15:0] ACK_NMI_ADDR_DEFAULT = 16'h0066;
  localparam logic [15:0] IRQ_VECTOR           = 16'h0038;

  // A read cycle on the acknowledge address retires a pending NMI.
  function automatic logic is_nmi_ack(input logic        valid,
                                      input logic [15:0] addr,
                                      input logic [15:0] ack_addr);
    return valid && (addr == ack_addr);
  endfunction

endpackage

// File: rtl/cpu_intgen_sync.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history
// flop; RISE is high for exactly one cycle after each synchronised 0->1.
module cpu_intgen_sync
  import cpu_intgen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ASYNC_IN,
  output logic RISE
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  // Shift the raw level through the synchroniser chain and keep one
  // cycle of history on its output for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ASYNC_IN};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign RISE = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/cpu_intgen.sv
// Z80 interrupt source: vblank-driven IRQ with a CPU enable latch, and a
// programmable periodic NMI acknowledged by a fetch from the NMI vector.
module cpu_intgen
  import cpu_intgen_pkg::*;
#(
  parameter int unsigned PRESCALE     = PRESCALE_DEFAULT,
  parameter logic [15:0] ACK_NMI_ADDR = ACK_NMI_ADDR_DEFAULT,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VBLK,
  input  logic        IRQEN_WE,
  input  logic        IRQEN_D,
  input  logic        NMI_WE,
  input  logic [7:0]  NMI_D,
  input  logic [15:0] AD,
  input  logic        AD_VALID,
  output logic        IRQ,
  output logic        NMI,
  output logic        NMI_OVR
);

  localparam int unsigned    PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic            vblk_rise;
  logic            irq_en_reg;
  logic            irq_reg;
  logic [7:0]      period_reg;
  logic [PS_W-1:0] presc_reg;
  logic [7:0]      unit_reg;
  logic            nmi_reg;
  logic            ovr_reg;
  logic            unit_tick;
  logic            expiry;
  logic            ack;

  cpu_intgen_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ASYNC_IN (VBLK),
    .RISE     (vblk_rise)
  );

  // Period of zero parks the counters, so ticks and expiries only exist
  // while a non-zero period is programmed.
  assign unit_tick = (period_reg != 8'd0) && (presc_reg == PS_LAST);
  assign expiry    = unit_tick && (unit_reg == (period_reg - 8'd1));
  assign ack       = is_nmi_ack(AD_VALID, AD, ACK_NMI_ADDR);

  // IRQ enable latch and request level; a clearing write beats a
  // same-cycle vblank rise, and a rise while disabled is simply lost.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else if (IRQEN_WE && !IRQEN_D) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (IRQEN_WE) begin
        irq_en_reg <= 1'b1;
      end
      if (vblk_rise && irq_en_reg) begin
        irq_reg <= 1'b1;
      end
    end
  end

  // NMI period timer, request level and overrun flag; a period write
  // restarts everything, and an expiry takes priority over an ack.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      period_reg <= 8'd0;
      presc_reg  <= '0;
      unit_reg   <= 8'd0;
      nmi_reg    <= 1'b0;
      ovr_reg    <= 1'b0;
    end else if (NMI_WE) begin
      period_reg <= NMI_D;
      presc_reg  <= '0;
      unit_reg   <= 8'd0;
      nmi_reg    <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      if (period_reg == 8'd0) begin
        presc_reg <= '0;
        unit_reg  <= 8'd0;
      end else begin
        presc_reg <= unit_tick ? '0 : presc_reg + 1'b1;
        if (unit_tick) begin
          unit_reg <= expiry ? 8'd0 : unit_reg + 8'd1;
        end
      end
      if (expiry) begin
        // An ack landing on the expiry consumes the old request, so it
        // is not counted as an overrun.
        if (nmi_reg && !ack) begin
          ovr_reg <= 1'b1;
        end
        nmi_reg <= 1'b1;
      end else if (ack) begin
        nmi_reg <= 1'b0;
      end
    end
  end

  assign IRQ     = irq_reg;
  assign NMI     = nmi_reg;
  assign NMI_OVR = ovr_reg;

endmodule
